// File: rtl/calc_pkg.sv
// Shared codes, widths and helpers for the calculator front-end controller.
package calc_pkg;

  localparam int DIGITS = 7;
  localparam int BCD_W  = 4;
  localparam int DIG_W  = DIGITS * BCD_W;

  localparam logic [2:0] ST_INPUT1    = 3'd0;
  localparam logic [2:0] ST_OP_SELECT = 3'd1;
  localparam logic [2:0] ST_INPUT2    = 3'd2;
  localparam logic [2:0] ST_RESULT    = 3'd3;
  localparam logic [2:0] ST_CALC      = 3'd4;

  localparam logic [1:0] OP_ADD = 2'd0;
  localparam logic [1:0] OP_SUB = 2'd1;
  localparam logic [1:0] OP_MUL = 2'd2;
  localparam logic [1:0] OP_DIV = 2'd3;

  localparam logic [2:0] DP_NONE = 3'd7;
  localparam logic [2:0] POS_MAX = 3'(DIGITS - 1);

  // Winning key after fixed-priority arbitration, highest priority first.
  typedef enum logic [3:0] {
    KEY_NONE, KEY_CONFIRM, KEY_BACK, KEY_SIGN, KEY_DOT,
    KEY_UP, KEY_DOWN, KEY_LEFT, KEY_RIGHT
  } key_e;

  typedef struct packed {
    logic [2:0]       state;
    logic [DIG_W-1:0] digits1;
    logic [DIG_W-1:0] digits2;
    logic [1:0]       operation;
    logic [2:0]       digit_pos;
    logic [2:0]       decimal_pos1;
    logic [2:0]       decimal_pos2;
    logic             is_negative1;
    logic             is_negative2;
    logic             alu_start;
    logic             timeout_err;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET = '{
    state: ST_INPUT1, digits1: '0, digits2: '0, operation: OP_ADD,
    digit_pos: '0, decimal_pos1: DP_NONE, decimal_pos2: DP_NONE,
    is_negative1: 1'b0, is_negative2: 1'b0, alu_start: 1'b0, timeout_err: 1'b0
  };

  // Non-BCD codes (>9) collapse to 0 in both directions.
  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

  function automatic logic [BCD_W-1:0] bcd_dec(input logic [BCD_W-1:0] d);
    if (d > 4'd9)  return 4'd0;
    if (d == 4'd0) return 4'd9;
    return d - 4'd1;
  endfunction

endpackage

// File: rtl/calc_controller_if.sv
// Key, ALU and display-register bundle between the calculator controller and its neighbours.
interface calc_controller_if;
  import calc_pkg::*;

  logic             key_up, key_down, key_left, key_right;
  logic             key_sign, key_dot, key_confirm, key_back;
  logic             alu_done;
  logic [DIG_W-1:0] result_digits;
  logic             result_neg;
  logic [2:0]       result_dp;

  logic [2:0]       state;
  logic [DIG_W-1:0] digits1, digits2;
  logic [1:0]       operation;
  logic [2:0]       digit_pos, decimal_pos1, decimal_pos2;
  logic             is_negative1, is_negative2;
  logic             blink_state, alu_start, timeout_err;

  modport master (
    output key_up, key_down, key_left, key_right, key_sign, key_dot, key_confirm, key_back,
    output alu_done, result_digits, result_neg, result_dp,
    input  state, digits1, digits2, operation, digit_pos, decimal_pos1, decimal_pos2,
    input  is_negative1, is_negative2, blink_state, alu_start, timeout_err
  );

  modport slave (
    input  key_up, key_down, key_left, key_right, key_sign, key_dot, key_confirm, key_back,
    input  alu_done, result_digits, result_neg, result_dp,
    output state, digits1, digits2, operation, digit_pos, decimal_pos1, decimal_pos2,
    output is_negative1, is_negative2, blink_state, alu_start, timeout_err
  );

endinterface

// File: rtl/calc_blink_gen.sv
// Blink phase for the digit under edit: toggles every BLINK_DIV cycles, restarts visible on a key.
module calc_blink_gen #(
  parameter int BLINK_DIV = 25000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart,
  input  logic enable,
  output logic blink_state
);
  localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] cnt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt         <= '0;
      blink_state <= 1'b1;
    end else if (!enable || restart) begin
      cnt         <= '0;
      blink_state <= 1'b1;
    end else if (cnt == CW'(BLINK_DIV - 1)) begin
      cnt         <= '0;
      blink_state <= ~blink_state;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/calc_controller.sv
// Calculator front-end sequencer: operand editing, operator select, ALU launch and result hand-off.
// Build option: define CALC_CHAIN_RESULT_EN to chain a RESULT into operand 1 on confirm.
module calc_controller
  import calc_pkg::*;
#(
  parameter int BLINK_DIV   = 25000000,
  parameter int ALU_TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst_n,
  calc_controller_if.slave bus
);
  localparam int TW = $clog2(ALU_TIMEOUT + 1);

  ctrl_t            q, d;
  key_e             win;
  logic             key_acc;
  logic [TW-1:0]    wait_cnt;
  logic             res_neg_q;
  logic [2:0]       res_dp_q;
  logic [DIG_W-1:0] ed_digits;
  logic             ed_neg;
  logic [2:0]       ed_dp;
  logic [BCD_W-1:0] ed_cur;

  always_comb begin
    win = KEY_NONE;
    if      (bus.key_confirm) win = KEY_CONFIRM;
    else if (bus.key_back)    win = KEY_BACK;
    else if (bus.key_sign)    win = KEY_SIGN;
    else if (bus.key_dot)     win = KEY_DOT;
    else if (bus.key_up)      win = KEY_UP;
    else if (bus.key_down)    win = KEY_DOWN;
    else if (bus.key_left)    win = KEY_LEFT;
    else if (bus.key_right)   win = KEY_RIGHT;
  end

  // A winning key counts as accepted only where it actually acts.
  assign key_acc = (win != KEY_NONE) && (q.state != ST_CALC)
                && !((q.state == ST_INPUT1) && (win == KEY_BACK));

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    d           = q;
    d.alu_start = 1'b0;
    ed_digits   = (q.state == ST_INPUT2) ? q.digits2      : q.digits1;
    ed_neg      = (q.state == ST_INPUT2) ? q.is_negative2 : q.is_negative1;
    ed_dp       = (q.state == ST_INPUT2) ? q.decimal_pos2 : q.decimal_pos1;
    ed_cur      = ed_digits[q.digit_pos*BCD_W +: BCD_W];

    unique case (q.state)
      ST_INPUT1, ST_INPUT2: begin
        unique case (win)
          KEY_CONFIRM: begin
            if (q.state == ST_INPUT1) begin
              d.state = ST_OP_SELECT;
            end else begin
              d.state     = ST_CALC;
              d.alu_start = 1'b1;
            end
          end
          KEY_BACK:  if (q.state == ST_INPUT2) d.state = ST_OP_SELECT;
          KEY_SIGN:  ed_neg = ~ed_neg;
          KEY_DOT:   ed_dp = (ed_dp == q.digit_pos) ? DP_NONE : q.digit_pos;
          KEY_UP:    ed_digits[q.digit_pos*BCD_W +: BCD_W] = bcd_inc(ed_cur);
          KEY_DOWN:  ed_digits[q.digit_pos*BCD_W +: BCD_W] = bcd_dec(ed_cur);
          KEY_LEFT:  if (q.digit_pos != POS_MAX) d.digit_pos = q.digit_pos + 3'd1;
          KEY_RIGHT: if (q.digit_pos != 3'd0)    d.digit_pos = q.digit_pos - 3'd1;
          default: ;
        endcase
        if (q.state == ST_INPUT1) begin
          d.digits1      = ed_digits;
          d.is_negative1 = ed_neg;
          d.decimal_pos1 = ed_dp;
        end else begin
          d.digits2      = ed_digits;
          d.is_negative2 = ed_neg;
          d.decimal_pos2 = ed_dp;
        end
      end

      ST_OP_SELECT: begin
        unique case (win)
          KEY_CONFIRM: begin
            d.state        = ST_INPUT2;
            d.digits2      = '0;
            d.is_negative2 = 1'b0;
            d.decimal_pos2 = DP_NONE;
            d.digit_pos    = '0;
          end
          KEY_BACK: begin
            d.state     = ST_INPUT1;
            d.digit_pos = '0;
          end
          KEY_UP:   d.operation = q.operation + 2'd1;
          KEY_DOWN: d.operation = q.operation - 2'd1;
          default: ;
        endcase
      end

      ST_CALC: begin
        if (bus.alu_done) begin
          d.state = ST_RESULT;
        end else if (wait_cnt == TW'(ALU_TIMEOUT - 1)) begin
          d.state       = ST_RESULT;
          d.timeout_err = 1'b1;
        end
      end

      ST_RESULT: begin
        unique case (win)
          KEY_CONFIRM: begin
`ifdef CALC_CHAIN_RESULT_EN
            if (q.timeout_err) begin
              d = CTRL_RESET;
            end else begin
              d.state        = ST_OP_SELECT;
              d.digits1      = bus.result_digits;
              d.is_negative1 = res_neg_q;
              d.decimal_pos1 = res_dp_q;
              d.digits2      = '0;
              d.digit_pos    = '0;
            end
`else
            d = CTRL_RESET;
`endif
          end
          KEY_BACK: begin
            d.state       = ST_INPUT2;
            d.timeout_err = 1'b0;
          end
          default: ;
        endcase
      end

      default: d = CTRL_RESET;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) q <= CTRL_RESET;
    else        q <= d;
  end

  // Wait counter and result-attribute capture are only live in CALC.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt  <= '0;
      res_neg_q <= 1'b0;
      res_dp_q  <= DP_NONE;
    end else begin
      wait_cnt <= (q.state == ST_CALC) ? wait_cnt + TW'(1) : '0;
      if ((q.state == ST_CALC) && bus.alu_done) begin
        res_neg_q <= bus.result_neg;
        res_dp_q  <= bus.result_dp;
      end
    end
  end

`ifndef CALC_CHAIN_RESULT_EN
  logic unused_chain;
  assign unused_chain = ^{res_neg_q, res_dp_q, bus.result_digits};
`endif

  calc_blink_gen #(.BLINK_DIV(BLINK_DIV)) u_blink (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (key_acc),
    .enable      ((q.state == ST_INPUT1) || (q.state == ST_INPUT2)),
    .blink_state (bus.blink_state)
  );

  assign bus.state        = q.state;
  assign bus.digits1      = q.digits1;
  assign bus.digits2      = q.digits2;
  assign bus.operation    = q.operation;
  assign bus.digit_pos    = q.digit_pos;
  assign bus.decimal_pos1 = q.decimal_pos1;
  assign bus.decimal_pos2 = q.decimal_pos2;
  assign bus.is_negative1 = q.is_negative1;
  assign bus.is_negative2 = q.is_negative2;
  assign bus.alu_start    = q.alu_start;
  assign bus.timeout_err  = q.timeout_err;

endmodule

// File: tb/tb_calc_controller.sv
// Directed bench for calc_controller: scoreboarded expectations checked by immediate assertions.
module tb_calc_controller;
  import calc_pkg::*;

  localparam logic [7:0] K_CONFIRM = 8'h80, K_BACK = 8'h40, K_SIGN = 8'h20, K_DOT = 8'h10;
  localparam logic [7:0] K_UP = 8'h08, K_DOWN = 8'h04, K_LEFT = 8'h02, K_RIGHT = 8'h01;

  typedef enum {F_STATE, F_DIGITS1, F_DIGITS2, F_OP, F_POS, F_DP1, F_DP2,
                F_NEG1, F_NEG2, F_BLINK, F_START, F_TOERR} field_e;
  typedef struct {
    field_e      f;
    logic [31:0] v;
    string       tag;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  keys = '0;
  logic        alu_done = 1'b0;
  logic [27:0] res_digits = '0;
  logic        res_neg = 1'b0;
  logic [2:0]  res_dp = '0;
  int          tests = 0;
  int          fails = 0;
  exp_t        sb[$];

  always #5 clk = ~clk;

  calc_controller_if bus();

  assign bus.key_confirm   = keys[7];
  assign bus.key_back      = keys[6];
  assign bus.key_sign      = keys[5];
  assign bus.key_dot       = keys[4];
  assign bus.key_up        = keys[3];
  assign bus.key_down      = keys[2];
  assign bus.key_left      = keys[1];
  assign bus.key_right     = keys[0];
  assign bus.alu_done      = alu_done;
  assign bus.result_digits = res_digits;
  assign bus.result_neg    = res_neg;
  assign bus.result_dp     = res_dp;

  calc_controller #(.BLINK_DIV(4), .ALU_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [31:0] observe(input field_e f);
    case (f)
      F_STATE:   return 32'(bus.state);
      F_DIGITS1: return 32'(bus.digits1);
      F_DIGITS2: return 32'(bus.digits2);
      F_OP:      return 32'(bus.operation);
      F_POS:     return 32'(bus.digit_pos);
      F_DP1:     return 32'(bus.decimal_pos1);
      F_DP2:     return 32'(bus.decimal_pos2);
      F_NEG1:    return 32'(bus.is_negative1);
      F_NEG2:    return 32'(bus.is_negative2);
      F_BLINK:   return 32'(bus.blink_state);
      F_START:   return 32'(bus.alu_start);
      default:   return 32'(bus.timeout_err);
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv)
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic expect_val(input field_e f, input logic [31:0] v, input string tag);
    exp_t e;
    e.f = f; e.v = v; e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check_sb();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, observe(e.f), e.v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] mask);
    keys = mask;
    tick();
    keys = '0;
  endtask

  task automatic expect_cleared(input string tag);
    expect_val(F_STATE,   0, {tag, "_state"});
    expect_val(F_DIGITS1, 0, {tag, "_digits1"});
    expect_val(F_DIGITS2, 0, {tag, "_digits2"});
    expect_val(F_OP,      0, {tag, "_op"});
    expect_val(F_POS,     0, {tag, "_pos"});
    expect_val(F_DP1,     7, {tag, "_dp1"});
    expect_val(F_DP2,     7, {tag, "_dp2"});
    expect_val(F_NEG1,    0, {tag, "_neg1"});
    expect_val(F_NEG2,    0, {tag, "_neg2"});
    expect_val(F_START,   0, {tag, "_start"});
    expect_val(F_TOERR,   0, {tag, "_toerr"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    tick(); tick();
    expect_cleared("reset");
    expect_val(F_BLINK, 1, "reset_blink");
    check_sb();
    rst_n = 1'b1;

    // Digit entry: up x3 on digit 0, left, up x12 on digit 1
    for (int i = 0; i < 3; i++) press(K_UP);
    expect_val(F_DIGITS1, 32'h3, "up3_digits1");
    check_sb();
    press(K_LEFT);
    expect_val(F_POS, 1, "left_pos");
    check_sb();
    for (int i = 0; i < 12; i++) press(K_UP);
    expect_val(F_DIGITS1, 32'h23, "up12_wrap_digits1");
    expect_val(F_POS, 1, "t1_pos");
    expect_val(F_STATE, 0, "t1_state");
    check_sb();

    // Decimal point toggle, sign, down-wrap from 0
    press(K_LEFT);
    press(K_DOT);
    expect_val(F_DP1, 2, "dot_set");
    check_sb();
    press(K_DOT);
    expect_val(F_DP1, 7, "dot_clear");
    check_sb();
    press(K_SIGN);
    expect_val(F_NEG1, 1, "sign_toggle");
    check_sb();
    press(K_RIGHT);
    press(K_RIGHT);
    press(K_RIGHT);
    expect_val(F_POS, 0, "right_saturate");
    check_sb();
    for (int i = 0; i < 3; i++) press(K_DOWN);
    expect_val(F_DIGITS1, 32'h20, "down3_digits1");
    check_sb();
    press(K_DOWN);
    expect_val(F_DIGITS1, 32'h29, "down_wrap_digits1");
    check_sb();

    // Operator select and ALU launch
    press(K_CONFIRM);
    expect_val(F_STATE, 1, "to_opsel");
    check_sb();
    press(K_DOWN);
    expect_val(F_OP, 3, "op_wrap_down");
    check_sb();
    press(K_CONFIRM);
    expect_val(F_STATE, 2, "to_input2");
    expect_val(F_DIGITS2, 0, "input2_digits2");
    expect_val(F_DP2, 7, "input2_dp2");
    expect_val(F_POS, 0, "input2_pos");
    check_sb();
    press(K_CONFIRM);
    expect_val(F_STATE, 4, "to_calc");
    expect_val(F_START, 1, "alu_start_hi");
    check_sb();
    tick();
    expect_val(F_START, 0, "alu_start_one_cycle");
    expect_val(F_STATE, 4, "calc_wait");
    check_sb();
    press(K_CONFIRM | K_BACK | K_UP);
    expect_val(F_STATE, 4, "calc_keys_ignored");
    expect_val(F_DIGITS2, 0, "calc_digits2");
    check_sb();
    tick(); tick(); tick();
    res_digits = 28'h1234567; res_neg = 1'b1; res_dp = 3'd3;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    expect_val(F_STATE, 3, "done_to_result");
    expect_val(F_TOERR, 0, "done_no_timeout");
    check_sb();
    press(K_BACK);
    expect_val(F_STATE, 2, "result_back");
    expect_val(F_DIGITS1, 32'h29, "result_back_digits1");
    expect_val(F_OP, 3, "result_back_op");
    check_sb();

    // ALU timeout: alu_done held low
    press(K_CONFIRM);
    expect_val(F_START, 1, "calc2_start");
    check_sb();
    n = 1;
    for (int i = 0; i < 40 && bus.state == ST_CALC; i++) begin
      tick();
      if (bus.state == ST_CALC) n++;
    end
    check("timeout_cycles", 32'(n), 32'd16);
    expect_val(F_STATE, 3, "timeout_result");
    expect_val(F_TOERR, 1, "timeout_flag");
    check_sb();
    press(K_CONFIRM);
    expect_cleared("full_clear");
    check_sb();

    // Simultaneous keys: confirm beats up
    press(K_UP);
    press(K_CONFIRM | K_UP);
    expect_val(F_STATE, 1, "prio_state");
    expect_val(F_DIGITS1, 32'h1, "prio_digits1");
    check_sb();

    // Reset mid-CALC, then a late alu_done
    press(K_CONFIRM);
    press(K_CONFIRM);
    expect_val(F_STATE, 4, "calc3");
    check_sb();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    alu_done = 1'b1;
    tick();
    alu_done = 1'b0;
    expect_cleared("late_done");
    check_sb();

    // Blink phase with BLINK_DIV=4
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      tick();
      expect_val(F_BLINK, 32'(((k / 4) % 2) == 0), $sformatf("blink_idle_%0d", k));
      check_sb();
    end
    press(K_LEFT);
    expect_val(F_BLINK, 1, "blink_key_restart");
    check_sb();
    for (int k = 1; k <= 4; k++) begin
      tick();
      expect_val(F_BLINK, 32'(k < 4), $sformatf("blink_after_key_%0d", k));
      check_sb();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/calc_controller.md
Name: calc_controller

Overview:
Sequencing controller for the calculator front end. It turns debounced key pulses into the operand, operator and state registers that the 8-digit display driver renders. It launches the arithmetic unit with a start/done handshake and generates the blink phase for the digit being edited. It sits between the key debouncer and the arithmetic unit / display driver, all on one system clock.

Parameters:
BLINK_DIV, 25000000, clk cycles per blink_state half-period (must be >= 2)
ALU_TIMEOUT, 1024, max clk cycles spent in CALC waiting for alu_done

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
key_up  in  1  one-cycle pulse: increment digit / next operation
key_down  in  1  one-cycle pulse: decrement digit / previous operation
key_left  in  1  one-cycle pulse: edit position toward MSD
key_right  in  1  one-cycle pulse: edit position toward LSD
key_sign  in  1  one-cycle pulse: toggle operand sign
key_dot  in  1  one-cycle pulse: set/clear decimal point at edit position
key_confirm  in  1  one-cycle pulse: advance state
key_back  in  1  one-cycle pulse: go back one state
alu_done  in  1  one-cycle pulse: result valid
result_digits  in  28  ALU result digits, 7x4 BCD, [3:0]=digit0 (LSD)
result_neg  in  1  ALU result sign
result_dp  in  3  ALU result decimal position
state  out  3  0=INPUT1, 1=OP_SELECT, 2=INPUT2, 3=RESULT, 4=CALC
digits1  out  28  operand 1, 7x4 BCD
digits2  out  28  operand 2, 7x4 BCD
operation  out  2  0=add, 1=sub, 2=mul, 3=div
digit_pos  out  3  edit position 0..6
decimal_pos1  out  3  operand 1 DP position, 7=none
decimal_pos2  out  3  operand 2 DP position, 7=none
is_negative1  out  1  operand 1 sign
is_negative2  out  1  operand 2 sign
blink_state  out  1  1=edit digit visible
alu_start  out  1  one-cycle launch pulse
timeout_err  out  1  sticky ALU timeout flag, cleared on leaving RESULT

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=INPUT1; digits1, digits2, operation, digit_pos = 0; decimal_pos1/2 = 7; signs, alu_start, timeout_err = 0; blink_state=1; blink counter=0.
  - Reset mid-CALC abandons the operation. A late alu_done is then ignored because it is only sampled in CALC.
- Key arbitration: at most one key acts per cycle, fixed priority confirm > back > sign > dot > up > down > left > right. Lower-priority keys in the same cycle are dropped.
- INPUT1 / INPUT2 (edit the respective operand):
  - up: digit[digit_pos] +1, wrapping 9->0. down: -1, wrapping 0->9. Non-BCD stored values (>9) force to 0 on up/down.
  - left: digit_pos+1, saturating at 6. right: digit_pos-1, saturating at 0.
  - sign: toggles the sign.
  - dot: decimal_pos = digit_pos; if already equal to digit_pos, decimal_pos = 7.
- Transitions, all registered and effective the cycle after the key pulse:
  - INPUT1 confirm -> OP_SELECT. back ignored.
  - OP_SELECT: up = operation+1 mod 4; down = operation-1 mod 4. confirm -> INPUT2, clearing digits2, is_negative2=0, decimal_pos2=7, digit_pos=0. back -> INPUT1, digits1 retained, digit_pos=0.
  - INPUT2 confirm -> CALC, with alu_start=1 for exactly the first CALC cycle. back -> OP_SELECT, digits2 retained.
  - CALC: all keys ignored. alu_done -> RESULT, and the controller captures result_neg/result_dp internally. If alu_done arrives on the same cycle as alu_start, it is accepted. If the wait counter reaches ALU_TIMEOUT without alu_done -> RESULT with timeout_err=1.
  - RESULT: confirm -> INPUT1 with full clear (same values as reset except blink counter). back -> INPUT2, operands retained.
- blink_state:
  - Toggles every BLINK_DIV cycles.
  - Any accepted key forces blink_state=1 and zeroes the counter on the next cycle.
  - Held at 1 outside INPUT1/INPUT2.

Optional Feature:
CALC_CHAIN_RESULT_EN
- Defined: RESULT confirm loads the result into operand 1 (digits1<=result_digits, is_negative1<=captured result_neg, decimal_pos1<=captured result_dp) and goes to OP_SELECT. operation is retained and digits2 is cleared. If timeout_err is set, RESULT confirm performs the full clear instead.
- Undefined: RESULT confirm performs the full clear described above.

Decomposition:
- Package calc_pkg:
  - state codes ST_INPUT1..ST_CALC
  - op codes OP_ADD..OP_DIV
  - DP_NONE=3'd7
  - DIGITS=7, BCD_W=4
- Sub-module calc_blink_gen:
  - inputs: clk, rst_n, restart, enable; output: blink_state
  - parameter BLINK_DIV

Test Plan:
1. Reset, then up x3, left, up x12 -> digits1=28'h0000023, digit_pos=1, state=0.
2. INPUT1 dot at pos 2 twice -> decimal_pos1=2, then 7. sign -> is_negative1=1. Then down at digit 0 from 0 -> digit0=9.
3. confirm, down, confirm, confirm -> operation=3, state path 1->2->4, alu_start high exactly 1 cycle. alu_done 5 cycles later -> state=3.
4. Hold alu_done low in CALC with ALU_TIMEOUT=16 -> RESULT after 16 cycles, timeout_err=1. confirm -> INPUT1, all cleared, timeout_err=0.
5. confirm and up pulsed on the same cycle in INPUT1 -> state=1, digits1 unchanged. rst_n low mid-CALC, then alu_done -> state stays 0.
6. BLINK_DIV=4, idle in INPUT1 -> blink_state toggles every 4 cycles. key_left mid-period -> blink_state=1 next cycle, then full 4-cycle period.
